mbimager_ddr_ctrl: RTL and testbench

- Host-to-DDR2 data mover for the MBImager board.
- Sits between the host endpoint fabric and one DDR2 controller user port (MCB-style command, write-data and read-data FIFOs).
- Buffers a host pipe-in block, writes it to DRAM in bursts on trigger, then on a read request reads the DRAM range back into a pipe-out buffer. Fill level and done status are reported to the host.

---
 rtl/mbimager_ddr_ctrl_if.sv | 33 +++
 rtl/mbimager_ddr_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_mbimager_ddr_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mbimager_ddr_ctrl_if.sv
// DDR2 controller user port (MCB-style): command, write-data and read-data FIFOs.
interface mbimager_ddr_ctrl_if #(parameter int ADDR_W = 30) ();
    logic              mem_cmd_en;
    logic [2:0]        mem_cmd_instr;
    logic [5:0]        mem_cmd_bl;
    logic [ADDR_W-1:0] mem_cmd_addr;
    logic              mem_cmd_full;
    logic              mem_wr_en;
    logic [31:0]       mem_wr_data;
    logic [3:0]        mem_wr_mask;
    logic              mem_wr_full;
    logic              mem_rd_en;
    logic [31:0]       mem_rd_data;
    logic              mem_rd_empty;

    modport master (
        output mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_addr,
        input  mem_cmd_full,
        output mem_wr_en, mem_wr_data, mem_wr_mask,
        input  mem_wr_full,
        output mem_rd_en,
        input  mem_rd_data, mem_rd_empty
    );

    modport slave (
        input  mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_addr,
        output mem_cmd_full,
        input  mem_wr_en, mem_wr_data, mem_wr_mask,
        output mem_wr_full,
        input  mem_rd_en,
        output mem_rd_data, mem_rd_empty
    );
endinterface

// File: rtl/mbimager_ddr_ctrl.sv
// Host pipe-in -> DDR2 burst writer and DDR2 -> host pipe-out burst reader.
// Word buffer with first-word-fall-through head; an empty buffer keeps showing the last popped word.
module mbimager_ddr_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [W-1:0]  last;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    assign do_push = push && (count != (PW+1)'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign head    = (count == '0) ? last : mem[rd_ptr];

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last   <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last   <= '0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (do_pop) begin
                rd_ptr <= nxt(rd_ptr);
                last   <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module mbimager_ddr_ctrl #(
    parameter int BL_WORDS  = 4,
    parameter int BUF_DEPTH = 16,
    parameter int ADDR_W    = 30
) (
    input  logic                       c3_clk0,
    input  logic                       c3_rst_n,
    input  logic [31:0]                ep00wire,
    input  logic [15:0]                ep01wire,
    input  logic [15:0]                ep02wire,
    input  logic [15:0]                ep03wire,
    input  logic [15:0]                ep04wire,
    input  logic                       ti40,
    input  logic                       ti41,
    input  logic                       pipe_in_write,
    input  logic [31:0]                pipe_in_data,
    input  logic                       pipe_out_read,
    output logic [31:0]                pipe_out_data,
    output logic                       to60,
    output logic [31:0]                ep30wire,
    output logic [31:0]                ep31wire,
    output logic [7:0]                 led,
    input  logic                       mem_calib_done,
    mbimager_ddr_ctrl_if.master        mem
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int BW = $clog2(BL_WORDS + 1);
    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(4 * BL_WORDS);

    typedef enum logic [2:0] {IDLE, WR_FILL, WR_CMD, WR_DONE, RD_CMD, RD_DRAIN} state_t;

    state_t            state, state_nxt;
    logic              soft_rst;
    logic [ADDR_W-1:0] addr, addr_inc, wr_start, rd_start, end_addr;
    logic [BW-1:0]     beat;
    logic              last_beat, load_wr, load_rd, addr_step;
    logic              rd_lock, done_sticky, wr_busy, rd_busy;
    logic [31:0]       pin_head;
    logic [PW:0]       pin_cnt, pout_cnt;
    logic              pin_empty, pout_room;
    logic              unused_ep00;

    assign soft_rst    = ep00wire[0];
    assign unused_ep00 = ^{ep00wire[31:4], ep00wire[1]};
    assign wr_start    = ADDR_W'(ep02wire);
    assign rd_start    = ADDR_W'(ep03wire);
    assign end_addr    = ADDR_W'(ep04wire);
    assign addr_inc    = addr + BURST_BYTES;
    assign last_beat   = (beat == BW'(BL_WORDS - 1));
    assign pin_empty   = (pin_cnt == '0);
    // A read burst is only requested once the whole burst is guaranteed to fit.
    assign pout_room   = (pout_cnt <= (PW+1)'(BUF_DEPTH - BL_WORDS));

    mbimager_ddr_fifo #(.DEPTH(BUF_DEPTH), .W(32)) u_pipe_in (
        .clk(c3_clk0), .rst_n(c3_rst_n), .clr(soft_rst | ti41),
        .push(pipe_in_write), .din(pipe_in_data), .pop(mem.mem_wr_en),
        .head(pin_head), .count(pin_cnt)
    );

    mbimager_ddr_fifo #(.DEPTH(BUF_DEPTH), .W(32)) u_pipe_out (
        .clk(c3_clk0), .rst_n(c3_rst_n), .clr(soft_rst),
        .push(mem.mem_rd_en), .din(mem.mem_rd_data), .pop(pipe_out_read),
        .head(pipe_out_data), .count(pout_cnt)
    );

    assign mem.mem_cmd_bl   = 6'(BL_WORDS - 1);
    assign mem.mem_cmd_addr = addr;
    assign mem.mem_wr_data  = pin_head;
    assign mem.mem_wr_mask  = 4'b0000;

    always_comb begin
        state_nxt         = state;
        mem.mem_cmd_en    = 1'b0;
        mem.mem_cmd_instr = 3'b000;
        mem.mem_wr_en     = 1'b0;
        mem.mem_rd_en     = 1'b0;
        load_wr           = 1'b0;
        load_rd           = 1'b0;
        addr_step         = 1'b0;
        if (!soft_rst) begin
            case (state)
                IDLE: begin
                    if (ti40 && ep00wire[3] && mem_calib_done) begin
                        load_wr   = 1'b1;
                        state_nxt = (wr_start >= end_addr) ? WR_DONE : WR_FILL;
                    end else if (ep00wire[2] && !rd_lock && mem_calib_done) begin
                        load_rd   = 1'b1;
                        state_nxt = (rd_start >= end_addr) ? IDLE : RD_CMD;
                    end
                end
                WR_FILL: begin
                    mem.mem_wr_en = !pin_empty && !mem.mem_wr_full;
                    if (mem.mem_wr_en && last_beat) state_nxt = WR_CMD;
                end
                WR_CMD: begin
                    mem.mem_cmd_en = !mem.mem_cmd_full;
                    if (mem.mem_cmd_en) begin
                        addr_step = 1'b1;
                        state_nxt = (addr_inc >= end_addr) ? WR_DONE : WR_FILL;
                    end
                end
                WR_DONE: state_nxt = IDLE;
                RD_CMD: begin
                    mem.mem_cmd_instr = 3'b001;
                    mem.mem_cmd_en    = !mem.mem_cmd_full && pout_room;
                    if (mem.mem_cmd_en) state_nxt = RD_DRAIN;
                end
                RD_DRAIN: begin
                    mem.mem_rd_en = !mem.mem_rd_empty;
                    if (mem.mem_rd_en && last_beat) begin
                        addr_step = 1'b1;
                        state_nxt = (addr_inc >= end_addr) ? IDLE : RD_CMD;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge c3_clk0 or negedge c3_rst_n) begin
        if (!c3_rst_n) begin
            state       <= IDLE;
            addr        <= '0;
            beat        <= '0;
            rd_lock     <= 1'b0;
            done_sticky <= 1'b0;
        end else if (soft_rst) begin
            state       <= IDLE;
            addr        <= '0;
            beat        <= '0;
            rd_lock     <= 1'b0;
            done_sticky <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_wr)        addr <= wr_start;
            else if (load_rd)   addr <= rd_start;
            else if (addr_step) addr <= addr_inc;
            if (state == IDLE)
                beat <= '0;
            else if (mem.mem_wr_en || mem.mem_rd_en)
                beat <= last_beat ? '0 : beat + BW'(1);
            // Held read request must drop before the next read may start.
            rd_lock <= ep00wire[2] && (rd_lock || load_rd);
            if (state == WR_DONE) done_sticky <= 1'b1;
        end
    end

    function automatic logic [7:0] fill_bytes(input logic [PW:0] cnt);
        int b;
        b = 4 * int'(cnt);
        return (b > 255) ? 8'hFF : 8'(b);
    endfunction

    assign wr_busy  = state inside {WR_FILL, WR_CMD, WR_DONE};
    assign rd_busy  = state inside {RD_CMD, RD_DRAIN};
    assign to60     = (state == WR_DONE) && !soft_rst;
    assign ep30wire = {13'b0, fill_bytes(pout_cnt), fill_bytes(pin_cnt), rd_busy, wr_busy, mem_calib_done};
    assign ep31wire = {16'b0, ep01wire};
    assign led      = ~{4'b0, rd_busy, wr_busy, done_sticky, mem_calib_done};
endmodule

// File: tb/tb_mbimager_ddr_ctrl.sv
// Scoreboard bench: stimulus queues expected commands/data, a negedge monitor with a DRAM model checks them.
module tb_mbimager_ddr_ctrl;
    logic        c3_clk0 = 1'b0;
    logic        c3_rst_n = 1'b0;
    logic [31:0] ep00wire = '0;
    logic [15:0] ep01wire = '0, ep02wire = '0, ep03wire = '0, ep04wire = '0;
    logic        ti40 = 1'b0, ti41 = 1'b0;
    logic        pipe_in_write = 1'b0;
    logic [31:0] pipe_in_data = '0;
    logic        pipe_out_read = 1'b0;
    logic [31:0] pipe_out_data;
    logic        to60;
    logic [31:0] ep30wire, ep31wire;
    logic [7:0]  led;
    logic        mem_calib_done = 1'b1;

    always #5 c3_clk0 = ~c3_clk0;

    mbimager_ddr_ctrl_if #(.ADDR_W(30)) mem ();

    mbimager_ddr_ctrl #(.BL_WORDS(4), .BUF_DEPTH(16), .ADDR_W(30)) dut (
        .c3_clk0(c3_clk0), .c3_rst_n(c3_rst_n), .ep00wire(ep00wire), .ep01wire(ep01wire),
        .ep02wire(ep02wire), .ep03wire(ep03wire), .ep04wire(ep04wire), .ti40(ti40), .ti41(ti41),
        .pipe_in_write(pipe_in_write), .pipe_in_data(pipe_in_data), .pipe_out_read(pipe_out_read),
        .pipe_out_data(pipe_out_data), .to60(to60), .ep30wire(ep30wire), .ep31wire(ep31wire),
        .led(led), .mem_calib_done(mem_calib_done), .mem(mem)
    );

    typedef struct packed {
        logic [2:0]  instr;
        logic [29:0] addr;
    } cmd_t;

    cmd_t        exp_cmd[$];
    logic [31:0] exp_wdata[$], exp_pout[$], wbuf[$], rdq[$];
    int          exp_done[$];
    logic [31:0] dram [logic [29:0]];
    logic [31:0] words [16];
    int          errors = 0, checks = 0, done_seen = 0;
    bit          bp = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge c3_clk0);
            #1;
        end
    endtask

    // Memory-side input drivers (change just after the active edge).
    initial begin
        mem.mem_cmd_full = 1'b0;
        mem.mem_wr_full  = 1'b0;
        mem.mem_rd_empty = 1'b1;
        mem.mem_rd_data  = '0;
        forever begin
            @(posedge c3_clk0);
            #1;
            mem.mem_cmd_full = bp && ($urandom_range(0, 2) == 0);
            mem.mem_wr_full  = bp && ($urandom_range(0, 2) == 0);
            mem.mem_rd_empty = (rdq.size() == 0) || (bp && ($urandom_range(0, 2) == 0));
            mem.mem_rd_data  = (rdq.size() != 0) ? rdq[0] : 32'h0;
        end
    end

    // Monitor + DRAM model.
    always @(negedge c3_clk0) begin
        if (c3_rst_n) begin
            if (mem.mem_wr_en) begin
                if (exp_wdata.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_unexpected: got %0h expected none", mem.mem_wr_data);
                end else
                    check("wr_data", 64'(mem.mem_wr_data), 64'(exp_wdata.pop_front()));
                check("wr_mask", 64'(mem.mem_wr_mask), 64'd0);
                wbuf.push_back(mem.mem_wr_data);
            end
            if (mem.mem_cmd_en) begin
                if (exp_cmd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL cmd_unexpected: got instr=%0d addr=%0h expected none",
                             mem.mem_cmd_instr, mem.mem_cmd_addr);
                end else begin
                    cmd_t c;
                    c = exp_cmd.pop_front();
                    check("cmd_instr", 64'(mem.mem_cmd_instr), 64'(c.instr));
                    check("cmd_addr", 64'(mem.mem_cmd_addr), 64'(c.addr));
                    check("cmd_bl", 64'(mem.mem_cmd_bl), 64'd3);
                end
                for (int i = 0; i < 4; i++) begin
                    logic [29:0] a;
                    a = mem.mem_cmd_addr + 30'(4 * i);
                    if (mem.mem_cmd_instr == 3'b000) begin
                        if (wbuf.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL wr_underrun: got 0 words expected 4 at %0h", a);
                        end else
                            dram[a] = wbuf.pop_front();
                    end else
                        rdq.push_back(dram.exists(a) ? dram[a] : (32'hDEAD0000 | 32'(a)));
                end
            end
            if (mem.mem_rd_en && rdq.size() != 0) void'(rdq.pop_front());
            if (to60) begin
                done_seen++;
                if (exp_done.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL to60_unexpected: got pulse expected none");
                end else
                    void'(exp_done.pop_front());
            end
            if (pipe_out_read) begin
                if (exp_pout.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pout_unexpected: got %0h expected none", pipe_out_data);
                end else
                    check("pipe_out_data", 64'(pipe_out_data), 64'(exp_pout.pop_front()));
            end
        end
    end

    task automatic load_words();
        ti41 = 1'b1;
        tick();
        ti41 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pipe_in_write = 1'b1;
            pipe_in_data  = words[i];
            exp_wdata.push_back(words[i]);
            tick();
        end
        pipe_in_write = 1'b0;
        tick();
        check("pin_fill_full", 64'(ep30wire[10:3]), 64'd64);
        check("pout_fill_empty", 64'(ep30wire[18:11]), 64'd0);
    endtask

    task automatic run_write(input int nbursts);
        int target;
        for (int k = 0; k < nbursts; k++) exp_cmd.push_back({3'b000, 30'(32'h10 + 16 * k)});
        exp_done.push_back(1);
        target = done_seen + 1;
        ti40 = 1'b1;
        tick();
        ti40 = 1'b0;
        for (int t = 0; t < 2000 && done_seen < target; t++) tick();
        check("to60_count", 64'(done_seen), 64'(target));
        tick();
        check("wr_idle", 64'(ep30wire[1]), 64'd0);
    endtask

    task automatic run_read();
        int t;
        for (int k = 0; k < 4; k++) exp_cmd.push_back({3'b001, 30'(32'h10 + 16 * k)});
        ep00wire = 32'h0000_000C;
        t = 0;
        tick();
        while (t < 2000 && !(ep30wire[18:11] == 8'd64 && ep30wire[2] == 1'b0)) begin
            tick();
            t++;
        end
        check("pout_fill_full", 64'(ep30wire[18:11]), 64'd64);
        tick(5);
        ep00wire = 32'h0000_0008;
        for (int i = 0; i < 16; i++) begin
            exp_pout.push_back(words[i]);
            pipe_out_read = 1'b1;
            tick();
        end
        // A strobe on the empty buffer keeps the last word on the output.
        exp_pout.push_back(words[15]);
        tick();
        pipe_out_read = 1'b0;
        tick();
        check("pout_fill_drained", 64'(ep30wire[18:11]), 64'd0);
        check("rd_idle", 64'(ep30wire[2]), 64'd0);
    endtask

    initial begin
        ep01wire = 16'hBEEF;
        tick(3);
        c3_rst_n = 1'b1;
        ep00wire = 32'h1;
        tick(2);
        ep00wire = 32'h0;
        tick();
        check("rst_to60", 64'(to60), 64'd0);
        check("rst_ep30", 64'(ep30wire), 64'h1);
        check("rst_pout", 64'(pipe_out_data), 64'd0);
        check("rst_led", 64'(led), 64'hFE);
        check("rst_ep31", 64'(ep31wire), 64'h0000_BEEF);
        check("rst_strobes", 64'({mem.mem_cmd_en, mem.mem_wr_en, mem.mem_rd_en}), 64'd0);

        // Directed write/read of a fixed pattern.
        ep02wire = 16'h0010;
        ep03wire = 16'h0010;
        ep04wire = 16'h0050;
        ep00wire = 32'h8;
        for (int i = 0; i < 16; i++) words[i] = {8'(i), 8'hC3, 8'(15 - i), 8'h5A};
        load_words();
        run_write(4);
        check("pin_fill_after_wr", 64'(ep30wire[10:3]), 64'd0);
        check("led_done_sticky", 64'(led), 64'hFC);
        run_read();

        // Same flow with random backpressure on all three memory FIFOs.
        bp = 1'b1;
        for (int i = 0; i < 16; i++) words[i] = $urandom;
        load_words();
        run_write(4);
        run_read();
        bp = 1'b0;
        tick(4);

        // Trigger without calibration is ignored.
        mem_calib_done = 1'b0;
        tick();
        ti40 = 1'b1;
        tick();
        ti40 = 1'b0;
        tick(20);
        check("nocal_busy", 64'(ep30wire[2:0]), 64'd0);
        mem_calib_done = 1'b1;
        tick();

        // Empty range: done pulse with no commands.
        ep04wire = 16'h0010;
        run_write(0);

        tick(10);
        check("left_cmd", 64'(exp_cmd.size()), 64'd0);
        check("left_wdata", 64'(exp_wdata.size()), 64'd0);
        check("left_pout", 64'(exp_pout.size()), 64'd0);
        check("left_done", 64'(exp_done.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
